// File: rtl/spi_cfg_master.sv
// ---------------------------------------------------------------------------
// spi_cfg_master
//
// Serial configuration master for an SPI_2909-style shift chain. After reset
// release it holds the chain in reset for GRST_CYCLES clocks, then accepts
// WIDTH-bit words on a start handshake. Each word is shifted out on spi_sin
// with a divided shift clock, the chain's serial return is captured in the
// same bit order, and a parallel-load strobe follows the last bit.
//
// Parameters:
//   WIDTH        bits per transaction (>= 2)
//   CLK_DIV      SCLK cycles per half-period of spi_clk (>= 1)
//   LSB_FIRST    0 = MSB shifted first, 1 = LSB shifted first
//   GRST_CYCLES  SCLK cycles spi_rst_n is held low after reset release (>= 1)
//
// Ports:
//   SCLK        system clock, rising edge
//   RST         asynchronous active-low reset
//   start       transaction request, accepted when busy = 0
//   wr_data     word to shift out, sampled on acceptance
//   regsel_in   register select, sampled on acceptance
//   busy        high during init and during a transaction
//   done        one-cycle pulse at transaction end
//   rd_data     word captured from spi_sout, updated with done
//   spi_clk     shift clock to the chain
//   spi_sin     serial data to the chain
//   spi_sout    serial data from the chain
//   spi_regsel  register select to the chain
//   spi_load    parallel-load strobe after the last bit
//   spi_rst_n   active-low chain reset
// ---------------------------------------------------------------------------
module spi_cfg_master #(
    parameter int WIDTH       = 32,
    parameter int CLK_DIV     = 4,
    parameter int LSB_FIRST   = 0,
    parameter int GRST_CYCLES = 16
) (
    input  logic             SCLK,
    input  logic             RST,
    input  logic             start,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             regsel_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] rd_data,
    output logic             spi_clk,
    output logic             spi_sin,
    input  logic             spi_sout,
    output logic             spi_regsel,
    output logic             spi_load,
    output logic             spi_rst_n
);

    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int INIT_W = (GRST_CYCLES > 1) ? $clog2(GRST_CYCLES) : 1;
    localparam int BIT_W  = $clog2(WIDTH);

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_SHIFT_LO,
        ST_SHIFT_HI,
        ST_LOAD,
        ST_DONE
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [DIV_W-1:0]    r_div_cnt;
    logic [INIT_W-1:0]   r_init_cnt;
    logic [BIT_W-1:0]    r_bit_cnt;
    logic [WIDTH-1:0]    r_shift;
    logic [WIDTH-1:0]    r_cap;
    logic [WIDTH-1:0]    r_rd_data;
    logic                r_regsel;
    logic                r_busy;
    logic                r_done;
    logic                r_spi_clk;
    logic                r_spi_load;
    logic                r_spi_rst_n;

    logic w_div_last;
    logic w_init_last;
    logic w_bit_last;
    logic w_accept;
    logic w_next_bit;
    logic w_capture;

    assign w_div_last  = (r_div_cnt == DIV_W'(CLK_DIV - 1));
    assign w_init_last = (r_init_cnt == INIT_W'(GRST_CYCLES - 1));
    assign w_bit_last  = (r_bit_cnt == BIT_W'(WIDTH - 1));
    assign w_accept    = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    // Advance to the next bit only when leaving SHIFT_HI for another SHIFT_LO,
    // so spi_sin changes on the same edge that drives spi_clk low.
    assign w_next_bit  = (r_state == ST_SHIFT_HI) && w_div_last && !w_bit_last;
    // Capture on the edge that enters SHIFT_HI (spi_clk rising).
    assign w_capture   = (r_state == ST_SHIFT_LO) && w_div_last;

    // NOTE: next-state defaults to the current state before the case, so
    // every path assigns w_next and no latch is inferred.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_INIT:     if (w_init_last) w_next = ST_IDLE;
            ST_IDLE:     if (start)       w_next = ST_SHIFT_LO;
            ST_SHIFT_LO: if (w_div_last)  w_next = ST_SHIFT_HI;
            ST_SHIFT_HI: if (w_div_last)  w_next = w_bit_last ? ST_LOAD : ST_SHIFT_LO;
            ST_LOAD:     if (w_div_last)  w_next = ST_DONE;
            ST_DONE:     w_next = start ? ST_SHIFT_LO : ST_IDLE;
            default:     w_next = ST_INIT;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge SCLK or negedge RST) begin
        if (!RST) r_state <= ST_INIT;
        else      r_state <= w_next;
    end

    always_ff @(posedge SCLK or negedge RST) begin
        if (!RST) begin
            r_div_cnt  <= '0;
            r_init_cnt <= '0;
            r_bit_cnt  <= '0;
        end else begin
            // Divider restarts on every state change; it only counts in the
            // timed states, where it never passes CLK_DIV-1.
            if (w_next != r_state)
                r_div_cnt <= '0;
            else if (r_state inside {ST_SHIFT_LO, ST_SHIFT_HI, ST_LOAD})
                r_div_cnt <= r_div_cnt + DIV_W'(1);

            if ((r_state == ST_INIT) && !w_init_last)
                r_init_cnt <= r_init_cnt + INIT_W'(1);

            if (w_accept)
                r_bit_cnt <= '0;
            else if (w_next_bit)
                r_bit_cnt <= r_bit_cnt + BIT_W'(1);
        end
    end

    // NOTE: the data registers are plain flops, not a memory array, so they
    // share the async reset; this gives rd_data and spi_sin defined values.
    always_ff @(posedge SCLK or negedge RST) begin
        if (!RST) begin
            r_shift   <= '0;
            r_cap     <= '0;
            r_rd_data <= '0;
            r_regsel  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_shift  <= wr_data;
                r_regsel <= regsel_in;
            end else if (w_next_bit) begin
                r_shift <= (LSB_FIRST != 0) ? {1'b0, r_shift[WIDTH-1:1]}
                                            : {r_shift[WIDTH-2:0], 1'b0};
            end

            // Fill from the opposite end to the shift-out end so a loopback
            // reproduces the original word.
            if (w_capture)
                r_cap <= (LSB_FIRST != 0) ? {spi_sout, r_cap[WIDTH-1:1]}
                                          : {r_cap[WIDTH-2:0], spi_sout};

            if ((r_state == ST_LOAD) && w_div_last)
                r_rd_data <= r_cap;
        end
    end

    // Pin-facing strobes are registered from the next state: same timing as
    // a state decode, but glitch-free at the chip pins.
    always_ff @(posedge SCLK or negedge RST) begin
        if (!RST) begin
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            r_spi_clk   <= 1'b0;
            r_spi_load  <= 1'b0;
            r_spi_rst_n <= 1'b0;
        end else begin
            r_busy      <= !((w_next == ST_IDLE) || (w_next == ST_DONE));
            r_done      <= (w_next == ST_DONE);
            r_spi_clk   <= (w_next == ST_SHIFT_HI);
            r_spi_load  <= (w_next == ST_LOAD);
            r_spi_rst_n <= (w_next != ST_INIT);
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign rd_data    = r_rd_data;
    assign spi_clk    = r_spi_clk;
    assign spi_sin    = (LSB_FIRST != 0) ? r_shift[0] : r_shift[WIDTH-1];
    assign spi_regsel = r_regsel;
    assign spi_load   = r_spi_load;
    assign spi_rst_n  = r_spi_rst_n;

endmodule

// File: tb/tb_spi_cfg_master.sv
// ---------------------------------------------------------------------------
// tb_spi_cfg_master
//
// Directed bench for spi_cfg_master. Three instances share clock and reset:
//   u_a  WIDTH=8,  CLK_DIV=2, MSB first, spi_sout looped back from spi_sin
//   u_b  WIDTH=8,  CLK_DIV=2, LSB first, spi_sout looped back or held at 1
//   u_c  WIDTH=32, CLK_DIV=1, MSB first, looped back
// Inputs are driven and outputs sampled on the falling edge of SCLK.
// ---------------------------------------------------------------------------
module tb_spi_cfg_master;

    logic SCLK;
    logic RST;

    int errors = 0;
    int checks = 0;

    // ---------------- instance A ----------------
    logic       a_start, a_regsel_in;
    logic [7:0] a_wr;
    logic       a_busy, a_done, a_clk, a_sin, a_regsel, a_load, a_rst_n;
    logic [7:0] a_rd;

    spi_cfg_master #(.WIDTH(8), .CLK_DIV(2), .LSB_FIRST(0), .GRST_CYCLES(16)) u_a (
        .SCLK(SCLK), .RST(RST), .start(a_start), .wr_data(a_wr),
        .regsel_in(a_regsel_in), .busy(a_busy), .done(a_done), .rd_data(a_rd),
        .spi_clk(a_clk), .spi_sin(a_sin), .spi_sout(a_sin),
        .spi_regsel(a_regsel), .spi_load(a_load), .spi_rst_n(a_rst_n)
    );

    // ---------------- instance B ----------------
    logic       b_start, b_regsel_in, b_loop, b_sout;
    logic [7:0] b_wr;
    logic       b_busy, b_done, b_clk, b_sin, b_regsel, b_load, b_rst_n;
    logic [7:0] b_rd;

    assign b_sout = b_loop ? b_sin : 1'b1;

    spi_cfg_master #(.WIDTH(8), .CLK_DIV(2), .LSB_FIRST(1), .GRST_CYCLES(16)) u_b (
        .SCLK(SCLK), .RST(RST), .start(b_start), .wr_data(b_wr),
        .regsel_in(b_regsel_in), .busy(b_busy), .done(b_done), .rd_data(b_rd),
        .spi_clk(b_clk), .spi_sin(b_sin), .spi_sout(b_sout),
        .spi_regsel(b_regsel), .spi_load(b_load), .spi_rst_n(b_rst_n)
    );

    // ---------------- instance C ----------------
    logic        c_start, c_regsel_in;
    logic [31:0] c_wr;
    logic        c_busy, c_done, c_clk, c_sin, c_regsel, c_load, c_rst_n;
    logic [31:0] c_rd;

    spi_cfg_master #(.WIDTH(32), .CLK_DIV(1), .LSB_FIRST(0), .GRST_CYCLES(16)) u_c (
        .SCLK(SCLK), .RST(RST), .start(c_start), .wr_data(c_wr),
        .regsel_in(c_regsel_in), .busy(c_busy), .done(c_done), .rd_data(c_rd),
        .spi_clk(c_clk), .spi_sin(c_sin), .spi_sout(c_sin),
        .spi_regsel(c_regsel), .spi_load(c_load), .spi_rst_n(c_rst_n)
    );

    // Observation mux for the two 8-bit instances.
    logic       obs_b;
    logic       m_busy, m_done, m_clk, m_sin, m_regsel, m_load;
    logic [7:0] m_rd;

    assign m_busy   = obs_b ? b_busy   : a_busy;
    assign m_done   = obs_b ? b_done   : a_done;
    assign m_clk    = obs_b ? b_clk    : a_clk;
    assign m_sin    = obs_b ? b_sin    : a_sin;
    assign m_regsel = obs_b ? b_regsel : a_regsel;
    assign m_load   = obs_b ? b_load   : a_load;
    assign m_rd     = obs_b ? b_rd     : a_rd;

    initial SCLK = 1'b0;
    always #5 SCLK = ~SCLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit use_b, input logic s, input logic [7:0] w, input logic rs);
        if (use_b) begin
            b_start = s; b_wr = w; b_regsel_in = rs;
        end else begin
            a_start = s; a_wr = w; a_regsel_in = rs;
        end
    endtask

    // Post-reset chain-reset window: spi_rst_n low and busy high before
    // rising edges 1..15, both flip after edge 16.
    task automatic init_watch();
        for (int k = 1; k <= 16; k++) begin
            @(negedge SCLK);
            check("init_seq", 64'({a_rst_n, a_busy, a_done, a_clk, a_load}),
                  64'({(k >= 16), (k < 16), 3'b000}));
        end
    endtask

    // One 8-bit, CLK_DIV=2 transaction: 35 cycles from acceptance to done.
    // Called at a falling edge where the instance is idle or in its done cycle.
    task automatic tx8(input bit use_b, input logic [7:0] word, input logic rs,
                       input bit lsb, input logic [7:0] exp_rd, input bit inject);
        int         rises;
        int         loads;
        int         n;
        int         hi;
        logic       prev_clk;
        logic [7:0] tmp;
        logic [3:0] ev;
        rises    = 0;
        loads    = 0;
        prev_clk = 1'b0;
        obs_b    = use_b;
        drive(use_b, 1'b1, word, rs);
        for (int c = 1; c <= 35; c++) begin
            @(negedge SCLK);
            if (c <= 32) begin
                n   = (c - 1) / 4;
                hi  = ((c - 1) / 2) % 2;
                ev  = {1'b1, 1'b0, hi[0], 1'b0};
                tmp = word >> (lsb ? n : 7 - n);
                check("sin_bit", 64'(m_sin), 64'(tmp[0]));
            end else if (c <= 34) begin
                ev = 4'b1001;
            end else begin
                ev = 4'b0100;
            end
            check("ctl_busy_done_clk_load", 64'({m_busy, m_done, m_clk, m_load}), 64'(ev));
            check("regsel_held", 64'(m_regsel), 64'(rs));
            if (m_clk && !prev_clk) rises++;
            prev_clk = m_clk;
            if (m_load) loads++;
            if (c == 1)            drive(use_b, 1'b0, word, rs);
            if (inject && c == 10) drive(use_b, 1'b1, 8'h3C, ~rs);
            if (inject && c == 11) drive(use_b, 1'b0, 8'h3C, ~rs);
        end
        check("rd_data", 64'(m_rd), 64'(exp_rd));
        check("clk_pulses", 64'(rises), 64'd8);
        check("load_cycles", 64'(loads), 64'd2);
    endtask

    initial begin
        logic [31:0] cw;
        logic [31:0] ctmp;
        logic [3:0]  cev;
        int          cn;
        int          chi;

        RST = 1'b0;
        obs_b = 1'b0;
        b_loop = 1'b0;
        a_start = 1'b0; a_wr = '0; a_regsel_in = 1'b0;
        b_start = 1'b0; b_wr = '0; b_regsel_in = 1'b0;
        c_start = 1'b0; c_wr = '0; c_regsel_in = 1'b0;

        // ---------------- reset and init ----------------
        repeat (5) @(negedge SCLK);
        check("reset_a", 64'({a_busy, a_done, a_clk, a_sin, a_load, a_regsel, a_rst_n}), 64'b1000000);
        check("reset_a_rd", 64'(a_rd), 64'h0);
        check("reset_bc", 64'({b_busy, b_rst_n, c_busy, c_rst_n, c_clk, c_sin}), 64'b101000);
        check("reset_c_rd", 64'(c_rd), 64'h0);
        RST = 1'b1;
        init_watch();
        check("init_done_bc", 64'({b_busy, b_rst_n, c_busy, c_rst_n}), 64'b0101);

        // ---------------- A: 0xA5 loopback, mid-shift start ignored ----------------
        tx8(1'b0, 8'hA5, 1'b1, 1'b0, 8'hA5, 1'b1);
        // Start in the done cycle: accepted back-to-back.
        tx8(1'b0, 8'h0F, 1'b0, 1'b0, 8'h0F, 1'b0);
        @(negedge SCLK);
        check("a_idle_after", 64'({a_busy, a_done, a_clk, a_load}), 64'b0000);
        check("a_rd_hold", 64'(a_rd), 64'h0F);

        // ---------------- B: LSB first ----------------
        tx8(1'b1, 8'hA5, 1'b1, 1'b1, 8'hFF, 1'b0);
        @(negedge SCLK);
        check("b_regsel_kept", 64'(b_regsel), 64'b1);
        b_loop = 1'b1;
        tx8(1'b1, 8'h13, 1'b0, 1'b1, 8'h13, 1'b0);
        @(negedge SCLK);

        // ---------------- C: CLK_DIV=1, WIDTH=32 ----------------
        cw = 32'hDEADBEEF;
        c_start = 1'b1; c_wr = cw; c_regsel_in = 1'b1;
        for (int c = 1; c <= 67; c++) begin
            @(negedge SCLK);
            if (c <= 64) begin
                cn   = (c - 1) / 2;
                chi  = (c - 1) % 2;
                cev  = {1'b1, 1'b0, chi[0], 1'b0};
                ctmp = cw >> (31 - cn);
                check("c_sin_bit", 64'(c_sin), 64'(ctmp[0]));
            end else if (c == 65) begin
                cev = 4'b1001;
            end else if (c == 66) begin
                cev = 4'b0100;
                check("c_rd_data", 64'(c_rd), 64'hDEADBEEF);
            end else begin
                cev = 4'b0000;
            end
            check("c_ctl", 64'({c_busy, c_done, c_clk, c_load}), 64'(cev));
            if (c <= 66) check("c_regsel", 64'(c_regsel), 64'b1);
            if (c == 1) c_start = 1'b0;
        end

        // ---------------- A: reset during bit 3 ----------------
        drive(1'b0, 1'b1, 8'h5A, 1'b1);
        for (int c = 1; c <= 13; c++) begin
            @(negedge SCLK);
            if (c == 1) drive(1'b0, 1'b0, 8'h5A, 1'b1);
        end
        // Cycle 13 is the first SHIFT_LO cycle of bit 3 (0x5A bit 4 = 1).
        check("abort_pre", 64'({a_clk, a_sin, a_busy, a_regsel}), 64'b0111);
        RST = 1'b0;
        #1;
        check("abort_reset", 64'({a_busy, a_done, a_clk, a_sin, a_load, a_regsel, a_rst_n}), 64'b1000000);
        check("abort_reset_rd", 64'(a_rd), 64'h0);
        repeat (2) @(negedge SCLK);
        RST = 1'b1;
        init_watch();
        for (int c = 0; c < 40; c++) begin
            @(negedge SCLK);
            check("abort_no_done", 64'({a_busy, a_done, a_load}), 64'b000);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_cfg_master.md
# spi_cfg_master

Parametrised serial configuration master, successor to the fixed 32-bit FPGA-to-SPI sequencer. On a `start` handshake it shifts a WIDTH-bit word into an external SPI_2909-style shift chain. It generates the shift clock from `SCLK` through a programmable divider, captures the chain's serial return into a readback register, and pulses a load strobe. It also drives the chain's reset after power-up and sits between the host logic and the chip pins.

## Interface
Parameters:
- WIDTH, 32: bits per transaction (≥2).
- CLK_DIV, 4: SCLK cycles per half-period of `spi_clk` (≥1).
- LSB_FIRST, 0: 0 = MSB shifted first; 1 = LSB shifted first.
- GRST_CYCLES, 16: SCLK cycles `spi_rst_n` is held low after reset release (≥1).

Ports (one clock; reset is asynchronous and active-low):
- SCLK  in  1  system clock; all logic is on the rising edge.
- RST  in  1  asynchronous active-low reset.
- start  in  1  transaction request; accepted only when `busy`=0.
- wr_data  in  WIDTH  word to shift out; sampled on acceptance.
- regsel_in  in  1  register select; sampled on acceptance.
- busy  out  1  high during init and during a transaction.
- done  out  1  one-cycle pulse when a transaction completes.
- rd_data  out  WIDTH  word captured from `spi_sout`; updated in the `done` cycle.
- spi_clk  out  1  shift clock to the chain.
- spi_sin  out  1  serial data to the chain.
- spi_sout  in  1  serial data from the chain.
- spi_regsel  out  1  register select to the chain; held for the whole transaction.
- spi_load  out  1  parallel-load strobe after the last bit.
- spi_rst_n  out  1  active-low chain reset.

## Operation
- States: INIT, IDLE, SHIFT_LO, SHIFT_HI, LOAD, DONE.
- INIT:
  - Entered on reset release.
  - `spi_rst_n`=0 for GRST_CYCLES cycles, then 1; the FSM then moves to IDLE.
  - `busy`=1 throughout.
- IDLE:
  - `busy`=0.
  - On `start`=1, the shift register is loaded with `wr_data`, `spi_regsel` is loaded with `regsel_in`, and the bit counter is cleared. The FSM moves to SHIFT_LO.
- SHIFT_LO:
  - `spi_clk`=0.
  - `spi_sin` = current bit (wr_data[WIDTH-1-n] MSB-first, wr_data[n] LSB-first).
  - Lasts CLK_DIV cycles, then the FSM moves to SHIFT_HI.
- SHIFT_HI:
  - `spi_clk`=1 and `spi_sin` is held.
  - `spi_sout` is registered into the capture register on the edge that drives `spi_clk` high. Capture order matches the shift order, so an external loopback reproduces `wr_data`.
  - Lasts CLK_DIV cycles. After the last bit the FSM moves to LOAD; otherwise the counter increments and the FSM returns to SHIFT_LO.
- LOAD:
  - `spi_clk`=0 and `spi_load`=1 for CLK_DIV cycles.
- DONE:
  - Lasts one cycle: `done`=1, `busy`=0, and `rd_data` takes the capture register value.
  - A `start` in this cycle is accepted (back-to-back).
  - The FSM then moves to IDLE, or to SHIFT_LO if `start` was accepted.
- Protocol rules:
  - `start` while `busy`=1 is ignored and not queued.
  - `wr_data` and `regsel_in` are don't-care outside the acceptance cycle.
  - `spi_regsel` keeps its value after the transaction until the next acceptance.
- Reset values (asserting RST, including mid-transaction, takes immediate effect): busy=1, done=0, rd_data=0, spi_clk=0, spi_sin=0, spi_load=0, spi_regsel=0, spi_rst_n=0, and the FSM is in INIT.
- Divider and bit counters are sized to clog2 of their range. There is no wrap-around inside a transaction: the bit counter terminates at WIDTH-1.

## Timing
- Acceptance edge = E0 (the rising edge of SCLK where `start`=1 and `busy`=0).
- Transaction length N = (2·WIDTH+1)·CLK_DIV cycles. `busy`=1 in cycles 1..N after E0, and `done`=1 in cycle N+1.
- Bit n timing:
  - `spi_sin` is valid from cycle 1+2n·CLK_DIV.
  - The `spi_clk` rising edge occurs at cycle 1+(2n+1)·CLK_DIV.
  - The `spi_clk` period is 2·CLK_DIV SCLK cycles at 50 % duty.
- `spi_sin` changes only while `spi_clk`=0; setup and hold to the `spi_clk` rise are each CLK_DIV cycles.
- `spi_sout` is sampled with zero added latency at the SHIFT_HI entry edge. The external chain must present data before the `spi_clk` rise.
- After reset release, the first `start` can be accepted in cycle GRST_CYCLES+1.

## Test plan
- Init: RST low 5 cycles, release; GRST_CYCLES=16 -> `spi_rst_n` low for exactly 16 cycles, `busy` falls in the same cycle `spi_rst_n` rises, all other outputs at reset values.
- Write, MSB-first, loopback: WIDTH=8, CLK_DIV=2, `spi_sout` tied to `spi_sin`, wr_data=0xA5 -> `spi_sin` sequence 1,0,1,0,0,1,0,1; 8 `spi_clk` pulses of period 4; `spi_load` high 2 cycles; `done` 35 cycles after E0; rd_data=0xA5.
- Write, LSB-first: LSB_FIRST=1, wr_data=0xA5 -> `spi_sin` sequence 1,0,1,0,0,1,0,1 reversed (i.e. 1,0,1,0,0,1,0,1 LSB→MSB). With `spi_sout` held at 1, rd_data=0xFF.
- Busy rules: `start` pulsed mid-shift with wr_data=0x3C -> ignored, first word completes unchanged. `start` in the `done` cycle with wr_data=0x0F -> accepted, `busy` high on the next cycle, second rd_data=0x0F under loopback.
- Reset mid-operation: assert RST at bit 3 -> all outputs take reset values immediately. After release, the INIT sequence repeats and no `done` is produced for the aborted word.
- Minimum divider: CLK_DIV=1, WIDTH=32, wr_data=0xDEADBEEF, loopback -> `spi_clk` toggles every cycle, `done` at cycle 66, rd_data=0xDEADBEEF, `spi_regsel` equals the sampled regsel_in throughout.
